simon_sequencer: RTL

Game-flow controller for Simon Says. Each round it samples the free-running 2-bit colour number from the rng block and appends it to a stored sequence. It then plays the whole sequence on the LED outputs and checks the player's button presses against it. It sits between rng, the button debouncers and the LED/display drivers, and reports win, loss and current round length.

---
 rtl/simon_pkg.sv | 20 ++
 rtl/simon_seq_mem.sv | 36 +++
 rtl/simon_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game-flow controller.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StAdd     = 3'd1;
  localparam state_t StShowOn  = 3'd2;
  localparam state_t StShowOff = 3'd3;
  localparam state_t StInput   = 3'd4;
  localparam state_t StDone    = 3'd5;

  // Width needed to hold a length in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return (max_len > 0) ? $clog2(max_len + 1) : 1;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: synchronous write, combinational read, no reset.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  color_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output color_t            rdata
);

  color_t mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == ADDR_W'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  // Decoded read so an address beyond DEPTH returns 0 instead of X.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game flow: grow the sequence, play it back on the LED, then check the presses.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 25000000,
  parameter int unsigned GAP_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned LEN_W         = len_w(MAX_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rand_num,
  input  logic             button_valid,
  input  logic [1:0]       button,
  output logic             led_en,
  output logic [1:0]       led_color,
  output logic             awaiting_input,
  output logic [LEN_W-1:0] round_len,
  output logic             game_over,
  output logic             win
);

  localparam int unsigned TMR_MAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_LAST = (TMR_MAX > 0) ? TMR_MAX - 1 : 0;
  localparam int unsigned TMR_W    = (TMR_LAST > 0) ? $clog2(TMR_LAST + 1) : 1;
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned TO_W     = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  localparam logic [TMR_W-1:0] ShowLast = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GapLast  = TMR_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             game_over_q, game_over_d;
  logic             win_q, win_d;

  logic             mem_we;
  color_t           cur_color;
  logic [LEN_W-1:0] last_idx;

  assign last_idx = len_q - LEN_W'(1);

  simon_seq_mem #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (LEN_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (len_q),
    .wdata (rand_num),
    .raddr (idx_q),
    .rdata (cur_color)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    to_d        = to_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    mem_we      = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d       = '0;
          game_over_d = 1'b0;
          win_d       = 1'b0;
          state_d     = StAdd;
        end
      end

      StAdd: begin
        mem_we  = 1'b1;
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        tmr_d   = ShowLast;
        state_d = StShowOn;
      end

      StShowOn: begin
        if (tmr_q == '0) begin
          tmr_d   = GapLast;
          state_d = StShowOff;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      StShowOff: begin
        if (tmr_q == '0) begin
          if (idx_q == last_idx) begin
            idx_d   = '0;
            to_d    = '0;
            state_d = StInput;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            tmr_d   = ShowLast;
            state_d = StShowOn;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      StInput: begin
        // A press on the timeout cycle wins over the timeout.
        if (button_valid) begin
          if (button != cur_color) begin
            game_over_d = 1'b1;
            state_d     = StDone;
          end else if (idx_q != last_idx) begin
            idx_d = idx_q + LEN_W'(1);
            to_d  = '0;
          end else if (len_q == LEN_W'(MAX_LEN)) begin
            win_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StAdd;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (to_q == TO_W'(TO_LAST)) begin
            game_over_d = 1'b1;
            state_d     = StDone;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      to_q        <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      to_q        <= to_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign led_en         = (state_q == StShowOn);
  assign led_color      = led_en ? cur_color : 2'd0;
  assign awaiting_input = (state_q == StInput);
  assign round_len      = len_q;
  assign game_over      = game_over_q;
  assign win            = win_q;

endmodule
